p_game_input: RTL and testbench

Upstream game-side front end for the Tetris processor subsystem. It synchronises and debounces the four raw player buttons, generates the gravity tick, and latches these as pending events on the `data_from_game` word. It also produces the `shape_num` word from a free-running LFSR. The processor reads both words through its register file, and a write to `data_to_game` acknowledges events and requests a new piece.

---
 rtl/p_game_input.sv | 110 +++++++++++
 tb/tb_p_game_input.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/p_game_input.sv
// p_game_input: button debounce, gravity tick, event latching and LFSR shape source for the Tetris processor
module p_game_input #(
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          GRAVITY_CYCLES  = 25000000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  btn_raw,
    input  logic [31:0] data_to_game,
    output logic [31:0] data_from_game,
    output logic [31:0] shape_num
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int GW = $clog2(GRAVITY_CYCLES);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] GR_MAX = GW'(GRAVITY_CYCLES - 1);

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_stable;
    logic [DW-1:0] r_db_cnt [4];
    logic [GW-1:0] r_grav_cnt;
    logic [4:0]    r_pending;
    logic [7:0]    r_seq;
    logic [1:0]    r_prev;
    logic [15:0]   r_lfsr;
    logic [2:0]    r_shape;
    logic [3:0]    w_btn_rise;
    logic [4:0]    w_new_events;
    logic          w_pause;
    logic          w_tick;
    logic          w_ack_edge;
    logic          w_req_edge;
    logic          w_fb;
    logic          w_unused;

    assign w_pause      = data_to_game[2];
    assign w_tick       = !w_pause && (r_grav_cnt == GR_MAX);
    assign w_ack_edge   = data_to_game[0] & ~r_prev[0];
    assign w_req_edge   = data_to_game[1] & ~r_prev[1];
    assign w_new_events = {w_tick, w_btn_rise};
    assign w_fb         = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_unused     = &{1'b0, data_to_game[31:3]};

    assign data_from_game = {|r_pending, 15'd0, r_seq, 3'd0, r_pending};
    assign shape_num      = {29'd0, r_shape};

    // A button event fires on the very edge its debounced level goes 0->1
    always_comb begin
        w_btn_rise = '0;
        for (int i = 0; i < 4; i++)
            w_btn_rise[i] = r_sync2[i] & ~r_stable[i] & (r_db_cnt[i] == DB_MAX);
    end

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clock) begin
        r_sync1 <= reset ? 4'd0 : btn_raw;
        r_sync2 <= reset ? 4'd0 : r_sync1;
    end

    // Accept a new button level only after it has been stable for the full debounce window
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stable <= '0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_MAX) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Gravity period counter, frozen while the processor holds pause
    always_ff @(posedge clock) begin
        if (reset) r_grav_cnt <= '0;
        else if (!w_pause) r_grav_cnt <= w_tick ? '0 : r_grav_cnt + GW'(1);
    end

    // Pending events and ack count; an event arriving with the ack survives it
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= '0;
            r_seq     <= '0;
            r_prev    <= '0;
        end else begin
            r_pending <= w_ack_edge ? w_new_events : (r_pending | w_new_events);
            r_seq     <= w_ack_edge ? r_seq + 8'd1 : r_seq;
            r_prev    <= data_to_game[1:0];
        end
    end

    // Free-running LFSR and shape pick; value 7 folds onto 0..3
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr  <= LFSR_SEED;
            r_shape <= '0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
            if (w_req_edge) r_shape <= (r_lfsr[2:0] == 3'd7) ? {1'b0, r_lfsr[4:3]} : r_lfsr[2:0];
        end
    end
endmodule

// File: tb/tb_p_game_input.sv
// tb_p_game_input: directed scenario checks for p_game_input with short debounce and gravity periods
module tb_p_game_input;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  btn_raw = '0;
    logic [3:0]  btn_idle = '0;
    logic [31:0] data_to_game = '0;
    logic [31:0] data_to_game2 = '0;
    logic [31:0] data_from_game;
    logic [31:0] data_from_game2;
    logic [31:0] shape_num;
    logic [31:0] shape_num2;
    logic [15:0] m_lfsr;
    int total = 0;
    int bad = 0;

    p_game_input #(.DEBOUNCE_CYCLES(4), .GRAVITY_CYCLES(10)) u_dut (
        .clock(clock), .reset(reset), .btn_raw(btn_raw), .data_to_game(data_to_game),
        .data_from_game(data_from_game), .shape_num(shape_num));

    p_game_input #(.DEBOUNCE_CYCLES(4), .GRAVITY_CYCLES(10), .LFSR_SEED(16'h001F)) u_dut2 (
        .clock(clock), .reset(reset), .btn_raw(btn_idle), .data_to_game(data_to_game2),
        .data_from_game(data_from_game2), .shape_num(shape_num2));

    always #5 clock = ~clock;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, default seed
    always @(posedge clock)
        m_lfsr <= reset ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        btn_raw = '0;
        data_to_game = '0;
        data_to_game2 = '0;
        step(3);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        btn_raw = '0;
        data_to_game = '0;
        step(3);
        total++; if (data_from_game !== 32'h0) begin bad++; $display("FAIL reset_dfg got=%h want=%h", data_from_game, 32'h0); end
        total++; if (shape_num !== 32'h0) begin bad++; $display("FAIL reset_shape got=%h want=%h", shape_num, 32'h0); end
        total++; if (shape_num2 !== 32'h0) begin bad++; $display("FAIL reset_shape2 got=%h want=%h", shape_num2, 32'h0); end
        reset = 1'b0;
        step(9);
        total++; if (data_from_game !== 32'h0) begin bad++; $display("FAIL grav_early got=%h want=%h", data_from_game, 32'h0); end
        step(1);
        total++; if (data_from_game !== 32'h8000_0010) begin bad++; $display("FAIL grav_first got=%h want=%h", data_from_game, 32'h8000_0010); end
        data_to_game[0] = 1'b1;
        step(1);
        total++; if (data_from_game !== 32'h0000_0100) begin bad++; $display("FAIL grav_ack got=%h want=%h", data_from_game, 32'h0000_0100); end
        data_to_game[0] = 1'b0;
        step(8);
        total++; if (data_from_game !== 32'h0000_0100) begin bad++; $display("FAIL grav_second_early got=%h want=%h", data_from_game, 32'h0000_0100); end
        step(1);
        total++; if (data_from_game !== 32'h8000_0110) begin bad++; $display("FAIL grav_second got=%h want=%h", data_from_game, 32'h8000_0110); end
    endtask

    task automatic test_debounce;
        do_reset();
        data_to_game[2] = 1'b1;
        btn_raw[2] = 1'b1;
        step(3);
        btn_raw[2] = 1'b0;
        step(10);
        total++; if (data_from_game !== 32'h0) begin bad++; $display("FAIL glitch got=%h want=%h", data_from_game, 32'h0); end
        btn_raw[2] = 1'b1;
        step(5);
        total++; if (data_from_game !== 32'h0) begin bad++; $display("FAIL press_early got=%h want=%h", data_from_game, 32'h0); end
        step(1);
        total++; if (data_from_game !== 32'h8000_0004) begin bad++; $display("FAIL press got=%h want=%h", data_from_game, 32'h8000_0004); end
        data_to_game[0] = 1'b1;
        step(1);
        total++; if (data_from_game !== 32'h0000_0100) begin bad++; $display("FAIL press_ack got=%h want=%h", data_from_game, 32'h0000_0100); end
        data_to_game[0] = 1'b0;
        step(13);
        total++; if (data_from_game !== 32'h0000_0100) begin bad++; $display("FAIL no_refire got=%h want=%h", data_from_game, 32'h0000_0100); end
        btn_raw[2] = 1'b0;
        step(10);
        total++; if (data_from_game !== 32'h0000_0100) begin bad++; $display("FAIL release_no_event got=%h want=%h", data_from_game, 32'h0000_0100); end
    endtask

    task automatic test_ack_race;
        do_reset();
        step(10);
        total++; if (data_from_game !== 32'h8000_0010) begin bad++; $display("FAIL race_tick got=%h want=%h", data_from_game, 32'h8000_0010); end
        data_to_game[2] = 1'b1;
        btn_raw[0] = 1'b1;
        step(6);
        total++; if (data_from_game !== 32'h8000_0011) begin bad++; $display("FAIL pre_race got=%h want=%h", data_from_game, 32'h8000_0011); end
        btn_raw[1] = 1'b1;
        step(5);
        data_to_game[0] = 1'b1;
        step(1);
        total++; if (data_from_game !== 32'h8000_0102) begin bad++; $display("FAIL ack_race got=%h want=%h", data_from_game, 32'h8000_0102); end
        step(5);
        total++; if (data_from_game !== 32'h8000_0102) begin bad++; $display("FAIL ack_hold got=%h want=%h", data_from_game, 32'h8000_0102); end
        data_to_game[0] = 1'b0;
        btn_raw = '0;
    endtask

    task automatic test_seq_wrap;
        do_reset();
        data_to_game[2] = 1'b1;
        for (int i = 0; i < 256; i++) begin
            data_to_game[0] = 1'b1;
            step(1);
            data_to_game[0] = 1'b0;
            step(1);
            if (i == 0) begin
                total++; if (data_from_game !== 32'h0000_0100) begin bad++; $display("FAIL seq_first got=%h want=%h", data_from_game, 32'h0000_0100); end
            end
            if (i == 254) begin
                total++; if (data_from_game !== 32'h0000_FF00) begin bad++; $display("FAIL seq_255 got=%h want=%h", data_from_game, 32'h0000_FF00); end
            end
        end
        total++; if (data_from_game !== 32'h0) begin bad++; $display("FAIL seq_wrap got=%h want=%h", data_from_game, 32'h0); end
    endtask

    task automatic test_shape;
        logic [2:0] exp;
        logic [6:0] seen;
        do_reset();
        data_to_game2[1] = 1'b1;
        step(1);
        total++; if (shape_num2 !== 32'd3) begin bad++; $display("FAIL seed_shape got=%h want=%h", shape_num2, 32'd3); end
        data_to_game2[1] = 1'b0;
        seen = '0;
        for (int i = 0; i < 1000; i++) begin
            exp = (m_lfsr[2:0] == 3'd7) ? {1'b0, m_lfsr[4:3]} : m_lfsr[2:0];
            data_to_game[1] = 1'b1;
            step(1);
            total++; if (shape_num !== {29'd0, exp}) begin bad++; $display("FAIL shape[%0d] got=%h want=%h", i, shape_num, {29'd0, exp}); end
            total++; if (shape_num > 32'd6) begin bad++; $display("FAIL shape_range[%0d] got=%h want<=6", i, shape_num); end
            if (shape_num < 32'd7) seen[shape_num[2:0]] = 1'b1;
            step(i % 3);
            data_to_game[1] = 1'b0;
            step(1 + (i * 7) % 5);
        end
        total++; if (seen !== 7'h7F) begin bad++; $display("FAIL shape_coverage got=%b want=%b", seen, 7'h7F); end
    endtask

    task automatic test_pause;
        do_reset();
        step(6);
        data_to_game[2] = 1'b1;
        step(50);
        total++; if (data_from_game !== 32'h0) begin bad++; $display("FAIL pause_no_tick got=%h want=%h", data_from_game, 32'h0); end
        data_to_game[2] = 1'b0;
        step(3);
        total++; if (data_from_game !== 32'h0) begin bad++; $display("FAIL pause_resume_early got=%h want=%h", data_from_game, 32'h0); end
        step(1);
        total++; if (data_from_game !== 32'h8000_0010) begin bad++; $display("FAIL pause_resume_tick got=%h want=%h", data_from_game, 32'h8000_0010); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_ack_race();
        test_seq_wrap();
        test_shape();
        test_pause();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
